// File: rtl/clk_div_ctrl.sv
// Programmable clock/strobe divider with start/stop, counted bursts and a
// one-deep pending config slot applied only at period boundaries.
module clk_div_ctrl #(
    parameter int W             = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int DEFAULT_PULSE = 0,
    parameter int CLK_IDLE_VAL  = 0
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_cfg_valid,
    output logic         o_cfg_ready,
    input  logic [W-1:0] i_cfg_div,
    input  logic         i_cfg_pulse,
    input  logic [W-1:0] i_cfg_burst,
    output logic         o_cfg_err,
    input  logic         i_start,
    input  logic         i_stop,
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_busy,
    output logic         o_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]   state, state_n;
    logic [W-1:0] cnt, cnt_n, per_cnt, per_cnt_n;
    logic [W-1:0] act_div, act_div_n, act_burst, act_burst_n;
    logic         act_pulse, act_pulse_n;
    logic [W-1:0] pend_div, pend_div_n, pend_burst, pend_burst_n;
    logic         pend_pulse, pend_pulse_n, pend_vld, pend_vld_n;
    logic         done_n, busy_n, tick_n, clk_n;
    logic         cfg_hs, cfg_bad, cfg_ok, stop_now, last_per;

    assign o_cfg_ready = ~pend_vld;
    assign cfg_hs      = i_cfg_valid & o_cfg_ready;
    assign cfg_bad     = i_cfg_div < W'(2);
    assign cfg_ok      = cfg_hs & ~cfg_bad;
    assign stop_now    = (state == S_STOP) | i_stop;
    assign last_per    = (act_burst != '0) && (per_cnt == act_burst - 1'b1);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        per_cnt_n    = per_cnt;
        act_div_n    = act_div;
        act_pulse_n  = act_pulse;
        act_burst_n  = act_burst;
        pend_div_n   = pend_div;
        pend_pulse_n = pend_pulse;
        pend_burst_n = pend_burst;
        pend_vld_n   = pend_vld;
        done_n       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (cfg_ok) begin
                    act_div_n   = i_cfg_div;
                    act_pulse_n = i_cfg_pulse;
                    act_burst_n = i_cfg_burst;
                end
                if (i_start && !i_stop) begin
                    state_n   = S_RUN;
                    per_cnt_n = '0;
                end
            end
            default: begin
                if (cfg_ok) begin
                    pend_div_n   = i_cfg_div;
                    pend_pulse_n = i_cfg_pulse;
                    pend_burst_n = i_cfg_burst;
                    pend_vld_n   = 1'b1;
                end
                if (cnt == act_div - 1'b1) begin
                    cnt_n = '0;
                    if (act_burst != '0)
                        per_cnt_n = per_cnt + 1'b1;
                    if (stop_now || last_per) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        // A config accepted on the final edge must not strand in the slot.
                        if (cfg_ok) begin
                            act_div_n   = i_cfg_div;
                            act_pulse_n = i_cfg_pulse;
                            act_burst_n = i_cfg_burst;
                            pend_vld_n  = 1'b0;
                        end
                    end
                    if (pend_vld) begin
                        act_div_n   = pend_div;
                        act_pulse_n = pend_pulse;
                        act_burst_n = pend_burst;
                        pend_vld_n  = 1'b0;
                        per_cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (stop_now)
                        state_n = S_STOP;
                end
            end
        endcase
    end

    // Outputs are registered from next-state values so o_clk never glitches.
    always_comb begin
        busy_n = (state_n != S_IDLE);
        tick_n = busy_n && (cnt_n == '0);
        clk_n  = 1'(CLK_IDLE_VAL);
        if (busy_n)
            clk_n = act_pulse_n ? (cnt_n == '0) : (cnt_n < (act_div_n >> 1));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            per_cnt    <= '0;
            act_div    <= W'(DEFAULT_DIV);
            act_pulse  <= 1'(DEFAULT_PULSE);
            act_burst  <= '0;
            pend_div   <= '0;
            pend_pulse <= 1'b0;
            pend_burst <= '0;
            pend_vld   <= 1'b0;
            o_clk      <= 1'(CLK_IDLE_VAL);
            o_tick     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            per_cnt    <= per_cnt_n;
            act_div    <= act_div_n;
            act_pulse  <= act_pulse_n;
            act_burst  <= act_burst_n;
            pend_div   <= pend_div_n;
            pend_pulse <= pend_pulse_n;
            pend_burst <= pend_burst_n;
            pend_vld   <= pend_vld_n;
            o_clk      <= clk_n;
            o_tick     <= tick_n;
            o_busy     <= busy_n;
            o_done     <= done_n;
            o_cfg_err  <= cfg_hs & cfg_bad;
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected per-cycle outputs are queued from
// the period arithmetic, then compared cycle by cycle on the falling edge.
module tb_clk_div_ctrl;
    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_cfg_valid = 1'b0;
    logic         o_cfg_ready;
    logic [W-1:0] i_cfg_div = '0;
    logic         i_cfg_pulse = 1'b0;
    logic [W-1:0] i_cfg_burst = '0;
    logic         o_cfg_err;
    logic         i_start = 1'b0;
    logic         i_stop = 1'b0;
    logic         o_clk, o_tick, o_busy, o_done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic clk, tick, busy, done, ready, err;
    } obs_t;

    obs_t exp_q[$];

    clk_div_ctrl #(.W(W), .DEFAULT_DIV(2), .DEFAULT_PULSE(0), .CLK_IDLE_VAL(0)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_div(i_cfg_div), .i_cfg_pulse(i_cfg_pulse), .i_cfg_burst(i_cfg_burst),
        .o_cfg_err(o_cfg_err), .i_start(i_start), .i_stop(i_stop),
        .o_clk(o_clk), .o_tick(o_tick), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic obs_t sample();
        obs_t s;
        s = {o_clk, o_tick, o_busy, o_done, o_cfg_ready, o_cfg_err};
        return s;
    endfunction

    task automatic push_period(input int div, input bit pulse);
        obs_t e;
        for (int c = 0; c < div; c++) begin
            e = '{clk: pulse ? (c == 0) : (c < div / 2), tick: (c == 0), busy: 1'b1,
                  done: 1'b0, ready: 1'b1, err: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done();
        obs_t e;
        e = '{clk: 1'b0, tick: 1'b0, busy: 1'b0, done: 1'b1, ready: 1'b1, err: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        obs_t e;
        e = '{clk: 1'b0, tick: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1, err: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic load_cfg(input int div, input bit pulse, input int burst);
        @(negedge i_clk);
        i_cfg_valid = 1'b1;
        i_cfg_div   = W'(div);
        i_cfg_pulse = pulse;
        i_cfg_burst = W'(burst);
        @(negedge i_clk);
        i_cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, got;
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        e = '{clk: 1'b0, tick: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1, err: 1'b0};
        got = sample();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_default_div();
        obs_t e, got;
        repeat (3) push_period(2, 1'b0);
        push_done();
        push_idle();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_stop  = (i == 4);
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL default_div cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_burst();
        obs_t e, got;
        @(negedge i_clk);
        i_cfg_valid = 1'b1;
        i_cfg_div   = W'(5);
        i_cfg_pulse = 1'b0;
        i_cfg_burst = W'(3);
        checks++;
        if (o_cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL burst_cfg_ready got=%b exp=1", o_cfg_ready);
        end
        @(negedge i_clk);
        i_cfg_valid = 1'b0;
        repeat (3) push_period(5, 1'b0);
        push_done();
        push_idle();
        push_idle();
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_reconfig_run();
        obs_t e, got;
        load_cfg(4, 1'b0, 0);
        push_period(4, 1'b0);
        push_period(7, 1'b0);
        push_done();
        push_idle();
        // slot is occupied from the handshake edge until the wrap
        for (int k = 2; k < 4; k++) begin
            e = exp_q[k];
            e.ready = 1'b0;
            exp_q[k] = e;
        end
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start     = 1'b0;
            i_cfg_valid = (i == 1);
            i_cfg_div   = W'(7);
            i_cfg_burst = '0;
            i_stop      = (i == 4);
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reconfig cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_reject();
        obs_t e, got;
        push_period(7, 1'b0);
        push_period(7, 1'b0);
        push_done();
        push_idle();
        e = exp_q[2];
        e.err = 1'b1;
        exp_q[2] = e;
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start     = 1'b0;
            i_cfg_valid = (i == 1);
            i_cfg_div   = W'(1);
            i_stop      = (i == 8);
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reject cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_stop_pulse();
        obs_t e, got;
        load_cfg(6, 1'b1, 0);
        push_period(6, 1'b1);
        push_period(6, 1'b1);
        push_done();
        push_idle();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_stop  = (i == 8);
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL stop_pulse cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_start_stop_same();
        obs_t e, got;
        repeat (3) push_idle();
        @(negedge i_clk);
        i_start = 1'b1;
        i_stop  = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_stop  = 1'b0;
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL start_stop_same cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, got;
        load_cfg(8, 1'b0, 0);
        push_period(8, 1'b0);
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL areset_pre cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        exp_q.delete();
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_clk !== 1'b0 || o_busy !== 1'b0 || o_tick !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate clk=%b busy=%b tick=%b exp=0,0,0", o_clk, o_busy, o_tick);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        push_period(2, 1'b0);
        push_period(2, 1'b0);
        push_done();
        push_idle();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_stop  = (i == 2);
            e = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL areset_post cyc=%0d got=%b exp=%b", i, got, e);
            end
        end
        i_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_burst();
        test_reconfig_run();
        test_reject();
        test_stop_pulse();
        test_start_stop_same();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
